vga_timing_gen: RTL

- Parametrised successor to the single-axis horizontal sync controller.
- Generates horizontal and vertical timing in one block: hsync, vsync, display enable, pixel x/y coordinates, and line/frame start strobes.
- Sync polarity is configurable per axis. A run enable is provided.
- A configurable output delay aligns all timing signals with a downstream pixel pipeline of known latency.
- Sits between the pixel clock domain and the pattern/framebuffer pixel source feeding the VGA DAC pins.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_axis_counter.sv | 53 +++++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity encoding and a small helper
// used by the timing generator and its axis counters.
package vga_pkg;

  // Sync polarity: the level a sync output takes while asserted.
  typedef enum logic {
    SYNC_NEG = 1'b0,
    SYNC_POS = 1'b1
  } sync_pol_e;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 1920x1080 @ 60 Hz (148.5 MHz pixel clock)
  localparam int VGA1080_H_ACTIVE = 1920;
  localparam int VGA1080_H_FP     = 88;
  localparam int VGA1080_H_SYNC   = 44;
  localparam int VGA1080_H_BP     = 148;
  localparam int VGA1080_V_ACTIVE = 1080;
  localparam int VGA1080_V_FP     = 4;
  localparam int VGA1080_V_SYNC   = 5;
  localparam int VGA1080_V_BP     = 36;

  // Length of one axis period in counter ticks.
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by vga_timing_gen towards the pixel source.
interface vga_timing_gen_if #(
  parameter int CNT_W = 12
);
  logic             h_sync;
  logic             v_sync;
  logic             video_enable;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    output h_sync, v_sync, video_enable, x, y, line_start, frame_start
  );

  modport slave (
    input h_sync, v_sync, video_enable, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus the decoded active and
// sync windows. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 8,
  parameter int FP     = 2,
  parameter int SYNC   = 3,
  parameter int BP     = 1,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             increment,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             in_sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Window edges; all fit in CNT_W because TOTAL <= 2^CNT_W and BP >= 1.
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
    $error("vga_axis_counter: every timing parameter must be at least 1");
  end

  if (TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("vga_axis_counter: axis total does not fit in CNT_W bits");
  end

  assign wrap    = increment & (count == LAST);
  assign active  = count < ACTIVE_END;
  assign in_sync = (count >= SYNC_START) && (count < SYNC_END);

  // Position counter: advances on increment and returns to 0 after LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Horizontal + vertical VGA timing generator. All outputs are registered
// once and then delayed by PIPE_DELAY further stages so they line up with a
// downstream pixel pipeline of matching latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA1080_H_ACTIVE,
  parameter int H_FP       = VGA1080_H_FP,
  parameter int H_SYNC     = VGA1080_H_SYNC,
  parameter int H_BP       = VGA1080_H_BP,
  parameter int V_ACTIVE   = VGA1080_V_ACTIVE,
  parameter int V_FP       = VGA1080_V_FP,
  parameter int V_SYNC     = VGA1080_V_SYNC,
  parameter int V_BP       = VGA1080_V_BP,
  parameter bit H_POL      = SYNC_NEG,
  parameter bit V_POL      = SYNC_NEG,
  parameter int CNT_W      = 12,
  parameter int PIPE_DELAY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  vga_timing_gen_if.master  vga
);

  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be within 0..15");
  end

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             ls;
    logic             fs;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } stage_t;

  // Value every pipeline stage takes in reset: syncs idle, strobes low.
  localparam stage_t IDLE = '{hs: !H_POL, vs: !V_POL, de: 1'b0, ls: 1'b0,
                              fs: 1'b0, x: '0, y: '0};

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_act;
  logic             v_act;
  logic             h_in;
  logic             v_in;
  logic             h_wrap;
  logic             v_wrap_unused;

  stage_t stage0;
  stage_t pipe [PIPE_DELAY+1];

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .increment (enable),
    .clear     (1'b0),
    .count     (h_cnt),
    .active    (h_act),
    .in_sync   (h_in),
    .wrap      (h_wrap)
  );

  // The vertical axis only moves when a line finishes, so vsync can only
  // change together with line_start.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .increment (h_wrap),
    .clear     (1'b0),
    .count     (v_cnt),
    .active    (v_act),
    .in_sync   (v_in),
    .wrap      (v_wrap_unused)
  );

  // Decode the current counter position into the raw timing signals.
  always_comb begin
    stage0    = IDLE;
    stage0.hs = h_in ? H_POL : !H_POL;
    stage0.vs = v_in ? V_POL : !V_POL;
    stage0.de = h_act & v_act & enable;
    stage0.ls = (h_cnt == '0) & enable;
    stage0.fs = (h_cnt == '0) & (v_cnt == '0) & enable;
    stage0.x  = h_cnt;
    stage0.y  = v_cnt;
  end

  // Output register followed by the alignment delay line; keeps shifting
  // even while counting is paused.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        pipe[i] <= IDLE;
      end
    end else begin
      pipe[0] <= stage0;
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign vga.h_sync       = pipe[PIPE_DELAY].hs;
  assign vga.v_sync       = pipe[PIPE_DELAY].vs;
  assign vga.video_enable = pipe[PIPE_DELAY].de;
  assign vga.line_start   = pipe[PIPE_DELAY].ls;
  assign vga.frame_start  = pipe[PIPE_DELAY].fs;
  assign vga.x            = pipe[PIPE_DELAY].x;
  assign vga.y            = pipe[PIPE_DELAY].y;

endmodule
